// File: rtl/puf_eval_sequencer.sv
// Sequences the dual-core PUF through one response: fetch the per-bit PDL configs
// byte by byte, trigger an evaluation, collect the bit, then write the response out.
module puf_eval_sequencer #(
  parameter int NUM_BITS             = 32,
  parameter int CFG_BYTES            = 16,
  parameter int INMEM_ADDRESS_WIDTH  = 17,
  parameter int OUTMEM_ADDRESS_WIDTH = 13,
  parameter int TIMEOUT_CYCLES       = 255
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  output logic                            busy,
  output logic                            done,
  output logic                            timeoutFlag,
  output logic                            inReadReq,
  input  logic                            inReadAck,
  output logic [INMEM_ADDRESS_WIDTH-1:0]  inReadAdd,
  input  logic                            inReadValid,
  input  logic [7:0]                      inReadData,
  output logic                            outWriteReq,
  input  logic                            outWriteAck,
  output logic [OUTMEM_ADDRESS_WIDTH-1:0] outWriteAdd,
  output logic [7:0]                      outWriteData,
  output logic [127:0]                    cfgCore0,
  output logic [127:0]                    cfgCore1,
  output logic [4:0]                      bitSel,
  output logic                            evalStart,
  input  logic                            evalDone,
  input  logic                            evalResult,
  output logic [31:0]                     response
);

  localparam int BW = $clog2(2*CFG_BYTES);
  localparam int TW = $clog2(TIMEOUT_CYCLES+1);

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, EVAL, EVAL_WAIT, WR, DONE} state_t;

  state_t          state, state_nxt;
  logic [4:0]      bit_idx;
  logic [BW-1:0]   byte_idx;
  logic [1:0]      wbyte;
  logic [TW-1:0]   timer;
  logic            last_byte, last_bit, last_wbyte, timed_out, eval_exit;

  assign last_byte  = (byte_idx == BW'(2*CFG_BYTES-1));
  assign last_bit   = (bit_idx == 5'(NUM_BITS-1));
  assign last_wbyte = (wbyte == 2'(NUM_BITS/8-1));
  assign timed_out  = (timer == TW'(TIMEOUT_CYCLES));
  // a done arriving on the timeout cycle wins
  assign eval_exit  = evalDone || timed_out;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    inReadReq    = 1'b0;
    inReadAdd    = '0;
    outWriteReq  = 1'b0;
    outWriteAdd  = '0;
    outWriteData = '0;
    evalStart    = 1'b0;
    done         = 1'b0;
    case (state)
      IDLE:      if (start) state_nxt = RD_REQ;
      RD_REQ: begin
        inReadReq = 1'b1;
        inReadAdd = INMEM_ADDRESS_WIDTH'(bit_idx) * INMEM_ADDRESS_WIDTH'(2*CFG_BYTES)
                  + INMEM_ADDRESS_WIDTH'(byte_idx);
        if (inReadAck) state_nxt = RD_WAIT;
      end
      RD_WAIT:   if (inReadValid) state_nxt = last_byte ? EVAL : RD_REQ;
      EVAL: begin
        evalStart = 1'b1;
        state_nxt = EVAL_WAIT;
      end
      EVAL_WAIT: if (eval_exit) state_nxt = last_bit ? WR : RD_REQ;
      WR: begin
        outWriteReq  = 1'b1;
        outWriteAdd  = OUTMEM_ADDRESS_WIDTH'(wbyte);
        outWriteData = response[8*int'(wbyte) +: 8];
        if (outWriteAck && last_wbyte) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy        <= 1'b0;
      timeoutFlag <= 1'b0;
      bit_idx     <= '0;
      byte_idx    <= '0;
      wbyte       <= '0;
      timer       <= '0;
      bitSel      <= '0;
      cfgCore0    <= '0;
      cfgCore1    <= '0;
      response    <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          busy        <= 1'b1;
          bit_idx     <= '0;
          byte_idx    <= '0;
          response    <= '0;
          timeoutFlag <= 1'b0;
        end
        RD_WAIT: if (inReadValid) begin
          if (int'(byte_idx) < CFG_BYTES) cfgCore0[8*int'(byte_idx) +: 8] <= inReadData;
          else cfgCore1[8*(int'(byte_idx)-CFG_BYTES) +: 8] <= inReadData;
          byte_idx <= last_byte ? '0 : byte_idx + 1'b1;
        end
        EVAL: begin
          bitSel <= bit_idx;
          timer  <= '0;
        end
        EVAL_WAIT: begin
          if (evalDone) response[bit_idx] <= evalResult;
          else if (timed_out) begin
            response[bit_idx] <= 1'b0;
            timeoutFlag       <= 1'b1;
          end else timer <= timer + 1'b1;
          if (eval_exit) begin
            if (last_bit) wbyte <= '0;
            else          bit_idx <= bit_idx + 1'b1;
          end
        end
        WR:   if (outWriteAck && !last_wbyte) wbyte <= wbyte + 1'b1;
        DONE: busy <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_puf_eval_sequencer.sv
// Directed bench for puf_eval_sequencer: byte-addressed memory model (data = addr[7:0]),
// PUF model answering bit[0] of its evaluation index, and a write-capture model.
module tb_puf_eval_sequencer;
  logic         clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic         busy, done, timeoutFlag;
  logic         inReadReq, inReadAck, inReadValid;
  logic [16:0]  inReadAdd;
  logic [7:0]   inReadData;
  logic         outWriteReq, outWriteAck;
  logic [12:0]  outWriteAdd;
  logic [7:0]   outWriteData;
  logic [127:0] cfgCore0, cfgCore1;
  logic [4:0]   bitSel;
  logic         evalStart, evalDone, evalResult;
  logic [31:0]  response;

  always #5 clk = ~clk;

  puf_eval_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .timeoutFlag(timeoutFlag), .inReadReq(inReadReq), .inReadAck(inReadAck),
    .inReadAdd(inReadAdd), .inReadValid(inReadValid), .inReadData(inReadData),
    .outWriteReq(outWriteReq), .outWriteAck(outWriteAck), .outWriteAdd(outWriteAdd),
    .outWriteData(outWriteData), .cfgCore0(cfgCore0), .cfgCore1(cfgCore1),
    .bitSel(bitSel), .evalStart(evalStart), .evalDone(evalDone),
    .evalResult(evalResult), .response(response)
  );

  int total = 0, bad = 0;

  // model knobs
  bit rand_lat = 0, stray = 0, wr_stall = 0, busy_pulse = 0;
  int fixed_lat = 1, timeout_bit = -1;

  // observations
  int rd_cnt, rd_seq_err, rd_overlap, eval_idx, bitsel_err, wait_cycles;
  int wr_cnt, wr_seq_err, stall_cnt, stall_err, done_cnt;
  logic [7:0]   wr_data [4];
  logic [127:0] c0_b0, c1_b0, c0_b9, c1_b9;
  logic [31:0]  resp_at_done;
  logic         to_at_done;

  // input memory: one read in flight, optional random ack delay and latency
  initial begin
    int ack_wait, pend;
    logic [16:0] pa;
    ack_wait = 0; pend = 0; pa = '0;
    inReadAck = 0; inReadValid = 0; inReadData = 0;
    forever begin
      @(negedge clk);
      inReadAck = 0; inReadValid = 0;
      if (reset) begin
        pend = 0; ack_wait = 0;
      end else if (pend > 0) begin
        if (inReadReq) rd_overlap++;
        pend--;
        if (pend == 0) begin inReadValid = 1; inReadData = pa[7:0]; end
      end else if (inReadReq) begin
        if (ack_wait > 0) ack_wait--;
        else begin
          inReadAck = 1;
          pa = inReadAdd;
          if (inReadAdd != 17'(rd_cnt)) rd_seq_err++;
          rd_cnt++;
          pend     = rand_lat ? int'($urandom_range(1, 4)) : fixed_lat;
          ack_wait = rand_lat ? int'($urandom_range(0, 7)) : 0;
        end
      end
    end
  end

  // PUF: answers bit[0] of the evaluation index three cycles after evalStart
  initial begin
    int cnt, b, w;
    bit waiting;
    cnt = 0; b = 0; w = 0; waiting = 0;
    evalDone = 0; evalResult = 0;
    forever begin
      @(negedge clk);
      evalDone = 0; evalResult = 0;
      if (reset) begin
        cnt = 0; waiting = 0;
      end else if (evalStart) begin
        b = eval_idx; eval_idx++;
        if (b == 0) begin c0_b0 = cfgCore0; c1_b0 = cfgCore1; end
        if (b == 9) begin c0_b9 = cfgCore0; c1_b9 = cfgCore1; end
        waiting = (b == timeout_bit);
        cnt = waiting ? 0 : 3;
        w = 0;
      end else if (cnt > 0) begin
        if (bitSel !== 5'(b)) bitsel_err++;
        cnt--;
        if (cnt == 0) begin evalDone = 1; evalResult = b[0]; end
      end else if (waiting) begin
        if (inReadReq) begin waiting = 0; wait_cycles = w; end
        else w++;
      end else if (stray && inReadReq) begin
        evalDone = 1; evalResult = 1;
      end
    end
  end

  // output memory: optional 5-cycle ack stall on byte 2
  initial begin
    outWriteAck = 0;
    forever begin
      @(negedge clk);
      outWriteAck = 0;
      if (!reset && outWriteReq) begin
        if (wr_stall && outWriteAdd == 13'd2 && stall_cnt < 5) begin
          if (outWriteData !== 8'hAA) stall_err++;
          stall_cnt++;
        end else begin
          outWriteAck = 1;
          if (outWriteAdd != 13'(wr_cnt)) wr_seq_err++;
          if (wr_cnt < 4) wr_data[wr_cnt] = outWriteData;
          wr_cnt++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      resp_at_done = response;
      to_at_done   = timeoutFlag;
    end
  end

  task automatic clear_obs();
    rd_cnt = 0; rd_seq_err = 0; rd_overlap = 0; eval_idx = 0; bitsel_err = 0;
    wait_cycles = -1; wr_cnt = 0; wr_seq_err = 0; stall_cnt = 0; stall_err = 0;
    done_cnt = 0; resp_at_done = 'x; to_at_done = 1'bx;
    c0_b0 = '0; c1_b0 = '0; c0_b9 = '0; c1_b9 = '0;
    foreach (wr_data[i]) wr_data[i] = 8'h00;
  endtask

  task automatic run(output bit ok);
    clear_obs();
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
    ok = 0;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      start = busy_pulse && (i == 50 || i == 1500);
      if (done_cnt > 0) begin ok = 1; break; end
    end
    start = 0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1;
    repeat (3) @(posedge clk);
    #1;
    total++; if ({busy, done, timeoutFlag, inReadReq, outWriteReq, evalStart} !== 6'b0) begin
      bad++; $display("FAIL reset_ctrl: got %b want 000000", {busy, done, timeoutFlag, inReadReq, outWriteReq, evalStart}); end
    total++; if ({inReadAdd, outWriteAdd, outWriteData, bitSel} !== '0) begin
      bad++; $display("FAIL reset_addr: got %h want 0", {inReadAdd, outWriteAdd, outWriteData, bitSel}); end
    total++; if ({cfgCore0, cfgCore1, response} !== '0) begin
      bad++; $display("FAIL reset_regs: got %h want 0", {cfgCore0, cfgCore1, response}); end
    @(negedge clk); reset = 0;
  endtask

  task automatic test_full_run();
    bit ok;
    run(ok);
    total++; if (!ok) begin bad++; $display("FAIL full_timeout: got no done want done"); end
    total++; if (rd_cnt !== 1024) begin bad++; $display("FAIL full_reads: got %0d want 1024", rd_cnt); end
    total++; if (rd_seq_err !== 0) begin bad++; $display("FAIL full_rd_seq: got %0d errs want 0", rd_seq_err); end
    total++; if (c0_b0[7:0] !== 8'h00 || c1_b0[7:0] !== 8'h10) begin
      bad++; $display("FAIL full_cfg_b0_low: got %h/%h want 00/10", c0_b0[7:0], c1_b0[7:0]); end
    total++; if (c0_b0 !== 128'h0F0E0D0C0B0A09080706050403020100) begin
      bad++; $display("FAIL full_cfg0_b0: got %h", c0_b0); end
    total++; if (c0_b9 !== 128'h2F2E2D2C2B2A29282726252423222120 || c1_b9 !== 128'h3F3E3D3C3B3A39383736353433323130) begin
      bad++; $display("FAIL full_cfg_b9: got %h %h", c0_b9, c1_b9); end
    total++; if (bitsel_err !== 0) begin bad++; $display("FAIL full_bitsel: got %0d errs want 0", bitsel_err); end
    total++; if (resp_at_done !== 32'hAAAAAAAA) begin bad++; $display("FAIL full_resp: got %h want aaaaaaaa", resp_at_done); end
    total++; if (to_at_done !== 1'b0) begin bad++; $display("FAIL full_tflag: got %b want 0", to_at_done); end
    total++; if (wr_cnt !== 4 || wr_seq_err !== 0) begin bad++; $display("FAIL full_writes: got %0d/%0d want 4/0", wr_cnt, wr_seq_err); end
    total++; if ({wr_data[3], wr_data[2], wr_data[1], wr_data[0]} !== 32'hAAAAAAAA) begin
      bad++; $display("FAIL full_wdata: got %h want aaaaaaaa", {wr_data[3], wr_data[2], wr_data[1], wr_data[0]}); end
    total++; if (done_cnt !== 1 || busy !== 1'b0) begin bad++; $display("FAIL full_done: got %0d busy=%b want 1 busy=0", done_cnt, busy); end
  endtask

  task automatic test_timeout();
    bit ok;
    timeout_bit = 5;
    run(ok);
    timeout_bit = -1;
    total++; if (!ok) begin bad++; $display("FAIL to_timeout: got no done want done"); end
    total++; if (resp_at_done !== 32'hAAAAAA8A) begin bad++; $display("FAIL to_resp: got %h want aaaaaa8a", resp_at_done); end
    total++; if (to_at_done !== 1'b1) begin bad++; $display("FAIL to_tflag: got %b want 1", to_at_done); end
    total++; if (wait_cycles !== 256) begin bad++; $display("FAIL to_wait_cycles: got %0d want 256", wait_cycles); end
    total++; if (wr_data[0] !== 8'h8A || wr_data[3] !== 8'hAA) begin bad++; $display("FAIL to_wdata: got %h/%h want 8a/aa", wr_data[0], wr_data[3]); end
    total++; if (rd_cnt !== 1024) begin bad++; $display("FAIL to_reads: got %0d want 1024", rd_cnt); end
  endtask

  task automatic test_random_latency();
    bit ok;
    rand_lat = 1;
    run(ok);
    rand_lat = 0;
    total++; if (!ok) begin bad++; $display("FAIL rnd_timeout: got no done want done"); end
    total++; if (rd_overlap !== 0) begin bad++; $display("FAIL rnd_overlap: got %0d want 0", rd_overlap); end
    total++; if (rd_seq_err !== 0 || rd_cnt !== 1024) begin bad++; $display("FAIL rnd_reads: got %0d errs %0d reads want 0/1024", rd_seq_err, rd_cnt); end
    total++; if (resp_at_done !== 32'hAAAAAAAA || to_at_done !== 1'b0) begin
      bad++; $display("FAIL rnd_resp: got %h tflag=%b want aaaaaaaa tflag=0", resp_at_done, to_at_done); end
  endtask

  task automatic test_abort();
    bit ok, hit;
    clear_obs();
    fixed_lat = 4;
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
    hit = 0;
    for (int i = 0; i < 5000; i++) begin
      @(posedge clk);
      if (rd_cnt >= 326) begin hit = 1; break; end
    end
    total++; if (!hit) begin bad++; $display("FAIL abort_reach: got %0d reads want 326", rd_cnt); end
    #1 reset = 1;
    @(posedge clk); #1;
    total++; if ({busy, done, timeoutFlag, inReadReq, outWriteReq, evalStart} !== 6'b0) begin
      bad++; $display("FAIL abort_ctrl: got %b want 000000", {busy, done, timeoutFlag, inReadReq, outWriteReq, evalStart}); end
    total++; if ({cfgCore0, cfgCore1, response, bitSel, inReadAdd} !== '0) begin
      bad++; $display("FAIL abort_regs: got nonzero want 0"); end
    repeat (2) @(negedge clk);
    reset = 0;
    repeat (5) @(negedge clk);
    total++; if (inReadReq !== 1'b0 || busy !== 1'b0 || rd_cnt !== 326) begin
      bad++; $display("FAIL abort_idle: got req=%b busy=%b reads=%0d want 0/0/326", inReadReq, busy, rd_cnt); end
    fixed_lat = 1;
    run(ok);
    total++; if (!ok || resp_at_done !== 32'hAAAAAAAA || rd_cnt !== 1024) begin
      bad++; $display("FAIL abort_rerun: got %h reads=%0d want aaaaaaaa/1024", resp_at_done, rd_cnt); end
    total++; if (c1_b0[7:0] !== 8'h10) begin bad++; $display("FAIL abort_cfg: got %h want 10", c1_b0[7:0]); end
  endtask

  task automatic test_busy_stray();
    bit ok;
    stray = 1; busy_pulse = 1;
    run(ok);
    stray = 0; busy_pulse = 0;
    total++; if (!ok) begin bad++; $display("FAIL busy_timeout: got no done want done"); end
    total++; if (resp_at_done !== 32'hAAAAAAAA) begin bad++; $display("FAIL busy_resp: got %h want aaaaaaaa", resp_at_done); end
    total++; if (rd_cnt !== 1024 || eval_idx !== 32) begin bad++; $display("FAIL busy_counts: got %0d/%0d want 1024/32", rd_cnt, eval_idx); end
    total++; if (done_cnt !== 1 || busy !== 1'b0) begin bad++; $display("FAIL busy_restart: got done=%0d busy=%b want 1/0", done_cnt, busy); end
  endtask

  task automatic test_write_stall();
    bit ok;
    wr_stall = 1;
    run(ok);
    wr_stall = 0;
    total++; if (!ok) begin bad++; $display("FAIL stall_timeout: got no done want done"); end
    total++; if (stall_cnt !== 5 || stall_err !== 0) begin bad++; $display("FAIL stall_hold: got %0d cycles %0d errs want 5/0", stall_cnt, stall_err); end
    total++; if (wr_cnt !== 4 || wr_seq_err !== 0) begin bad++; $display("FAIL stall_writes: got %0d/%0d want 4/0", wr_cnt, wr_seq_err); end
    total++; if (wr_data[2] !== 8'hAA) begin bad++; $display("FAIL stall_data: got %h want aa", wr_data[2]); end
  endtask

  initial begin
    clear_obs();
    test_reset();
    test_full_run();
    test_timeout();
    test_random_latency();
    test_abort();
    test_busy_stray();
    test_write_stall();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
